fp_mant_align: RTL and testbench
================================

Name: fp_mant_align

Overview:
- Alignment stage of the 32-bit floating-point adder, directly downstream of the 8-bit exponent adder/subtractor.
- Consumes the exponent-difference magnitude and the A>=B flag (subtractor carry-out).
- Swaps operands so the larger-exponent mantissa is "big" and right-shifts the smaller mantissa by the difference, producing guard/round/sticky bits.
- Shifting is iterative, STEP bits per cycle, with valid/ready handshakes on input and output; the mantissa add/sub stage consumes the result.

Parameters:
- EXP_W, 8, exponent and exponent-difference width.
- MANT_W, 24, mantissa width including hidden bit.
- STEP, 4, maximum right-shift distance per SHIFT cycle (1..MANT_W+2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands.
- exp_a  in  EXP_W  exponent of operand A.
- exp_b  in  EXP_W  exponent of operand B.
- mant_a  in  MANT_W  mantissa of A.
- mant_b  in  MANT_W  mantissa of B.
- exp_diff  in  EXP_W  |exp_a - exp_b|, from the subtractor Difference output.
- a_ge_b  in  1  1 when exp_a >= exp_b (subtractor Cout).
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- exp_out  out  EXP_W  larger exponent.
- big_mant  out  MANT_W  larger-exponent mantissa, unshifted.
- small_mant  out  MANT_W  aligned smaller mantissa.
- guard  out  1  first bit shifted out below the LSB.
- round_bit  out  1  second bit shifted out.
- sticky  out  1  OR of all bits shifted out beyond round_bit.
- swapped  out  1  1 when B was selected as big.

Behaviour:
- Reset (rst_n low at a clk edge): state goes to IDLE. All outputs are 0, including in_ready and out_valid, while rst_n is low. Reset aborts any operation in flight; no partial result is ever presented.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE) && rst_n. out_valid = (state == DONE).
- IDLE: an accept occurs when in_valid && in_ready.
  - a_ge_b = 1: big = A, small = B, exp_out = exp_a, swapped = 0.
  - a_ge_b = 0: big = B, small = A, exp_out = exp_b, swapped = 1.
  - guard, round_bit and sticky clear to 0.
  - remaining = exp_diff.
- Next state after accept:
  - exp_diff == 0 → DONE.
  - exp_diff > MANT_W+2 (flush) → DONE; small = 0, guard = round_bit = 0, sticky = |small input.
  - Otherwise → SHIFT.
- SHIFT: each cycle, k = min(STEP, remaining).
  - The extended vector {small, guard, round_bit} shifts right by k.
  - sticky |= OR of every bit dropped past round_bit, including the prior round_bit and guard when k is 2 or more.
  - remaining -= k. When remaining reaches 0, go to DONE.
- DONE: outputs hold stable until out_ready. On out_valid && out_ready go to IDLE. No new input is accepted in the same cycle (no back-to-back overlap).
- Latency from accept edge t:
  - out_valid is high from t+1 when d == 0 or flush.
  - Otherwise out_valid is high from t+1+ceil(d/STEP).
- Inputs are sampled only at accept. Later changes to inputs have no effect.
- Shift arithmetic is unsigned. remaining never underflows.

Optional Feature:
- Macro: FP_ALIGN_ZERO_BYPASS_EN.
- Defined: at accept, if the selected small mantissa == 0, go directly to DONE with small = 0 and guard/round_bit/sticky = 0, whatever exp_diff is. Latency is 1.
- Undefined: zero mantissas take the normal SHIFT path. Outputs are identical; only latency differs.

Decomposition:
- Shared package fp_add_pkg holds:
  - EXP_W and MANT_W constants;
  - the GRS width constant (3);
  - the alignment state encoding (IDLE/SHIFT/DONE).
- Sub-module fp_sticky_shift_step: combinational right shift of {mant, g, r} by 0..STEP, returning the shifted vector and the OR of dropped bits. It is instantiated once; the FSM and registers live in fp_mant_align.

Test Plan:
- mant_a=0xC00000, exp_a=0x85, mant_b=0x800000, exp_b=0x83, exp_diff=2, a_ge_b=1, STEP=4 → at t+2: small_mant=0x200000, big_mant=0xC00000, exp_out=0x85, g/r/s=0/0/0, swapped=0.
- Same mantissas, a_ge_b=0, exp_diff=5 → big_mant=0x800000, small_mant=0x060000, swapped=1, out_valid at t+3.
- Small=0x800001, exp_diff=3 → small_mant=0x100000, guard=0, round_bit=0, sticky=1.
- exp_diff=30, small=0x000001 → small_mant=0, guard=0, round_bit=0, sticky=1, out_valid at t+1.
- Hold out_ready=0 for 3 cycles in DONE while driving a new in_valid → outputs stable, in_ready=0, second operand not accepted until the cycle after the out_ready handshake.
- exp_diff=20, STEP=4, rst_n low at t+2 → next edge: out_valid=0, in_ready=0, all outputs 0. After release: IDLE with in_ready=1 and no stale result.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared constants and alignment state encoding for the FP adder datapath.
package fp_add_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int GRS_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_e;

endpackage

// File: rtl/fp_sticky_shift_step.sv
// One combinational alignment step: right-shift {mant, g, r} by 0..STEP and
// report whether any set bit fell off the bottom of the vector.
module fp_sticky_shift_step #(
  parameter int W    = 26,
  parameter int STEP = 4,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  vec_in,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  vec_out,
  output logic          dropped
);

  always_comb begin
    vec_out = vec_in >> k;
    dropped = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(k)) dropped = dropped | vec_in[i];
    end
  end

endmodule

// File: rtl/fp_mant_align.sv
// Mantissa alignment stage: swaps operands by exponent and shifts the smaller
// mantissa STEP bits per cycle. Define FP_ALIGN_ZERO_BYPASS_EN to skip shifting zero mantissas.
module fp_mant_align #(
  parameter int EXP_W  = fp_add_pkg::EXP_W,
  parameter int MANT_W = fp_add_pkg::MANT_W,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic [EXP_W-1:0]  exp_diff,
  input  logic              a_ge_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] big_mant,
  output logic [MANT_W-1:0] small_mant,
  output logic              guard,
  output logic              round_bit,
  output logic              sticky,
  output logic              swapped
);
  import fp_add_pkg::*;

  // sticky lives outside the shift vector, so the vector is {mant, g, r}
  localparam int VW = MANT_W + GRS_W - 1;
  localparam int KW = $clog2(STEP + 1);
  localparam logic [EXP_W-1:0] STEP_E  = EXP_W'(STEP);
  localparam logic [EXP_W-1:0] FLUSH_E = EXP_W'(MANT_W + 2);
  localparam logic [KW-1:0]    STEP_K  = KW'(STEP);

  align_state_e      state, state_d;
  logic [EXP_W-1:0]  remaining, exp_r;
  logic [MANT_W-1:0] big_r, sel_small;
  logic [VW-1:0]     vec_r, vec_sh;
  logic              sticky_r, swapped_r, dropped;
  logic [KW-1:0]     k;
  logic              accept, flush, skip;

  assign accept    = in_valid && in_ready;
  assign sel_small = a_ge_b ? mant_b : mant_a;
  assign flush     = exp_diff > FLUSH_E;
`ifdef FP_ALIGN_ZERO_BYPASS_EN
  assign skip = (exp_diff == '0) || flush || (sel_small == '0);
`else
  assign skip = (exp_diff == '0) || flush;
`endif
  assign k = (remaining > STEP_E) ? STEP_K : remaining[KW-1:0];

  fp_sticky_shift_step #(.W(VW), .STEP(STEP)) u_step (
    .vec_in  (vec_r),
    .k       (k),
    .vec_out (vec_sh),
    .dropped (dropped)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = skip ? DONE : SHIFT;
      SHIFT:   if (remaining == EXP_W'(k)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      exp_r     <= '0;
      big_r     <= '0;
      vec_r     <= '0;
      sticky_r  <= 1'b0;
      swapped_r <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        exp_r     <= a_ge_b ? exp_a : exp_b;
        big_r     <= a_ge_b ? mant_a : mant_b;
        swapped_r <= !a_ge_b;
        remaining <= exp_diff;
        // past MANT_W+2 every bit lands in sticky, so skip the iteration
        if (flush) begin
          vec_r    <= '0;
          sticky_r <= |sel_small;
        end else begin
          vec_r    <= {sel_small, 2'b00};
          sticky_r <= 1'b0;
        end
      end else if (state == SHIFT) begin
        vec_r     <= vec_sh;
        sticky_r  <= sticky_r | dropped;
        remaining <= remaining - EXP_W'(k);
      end
    end
  end

  assign in_ready   = (state == IDLE) && rst_n;
  assign out_valid  = (state == DONE) && rst_n;
  assign exp_out    = rst_n ? exp_r : '0;
  assign big_mant   = rst_n ? big_r : '0;
  assign small_mant = rst_n ? vec_r[VW-1:GRS_W-1] : '0;
  assign guard      = rst_n && vec_r[1];
  assign round_bit  = rst_n && vec_r[0];
  assign sticky     = rst_n && sticky_r;
  assign swapped    = rst_n && swapped_r;

endmodule

// File: tb/tb_fp_mant_align.sv
// Self-checking bench for fp_mant_align: directed cases, handshake hold,
// mid-operation reset and random operands against an arithmetic reference.
module tb_fp_mant_align;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, a_ge_b, out_valid, out_ready;
  logic [7:0]  exp_a, exp_b, exp_diff, exp_out;
  logic [23:0] mant_a, mant_b, big_mant, small_mant;
  logic        guard, round_bit, sticky, swapped;

  int checks = 0;
  int failures = 0;

  logic [7:0]  m_exp;
  logic [23:0] m_big, m_small;
  logic        m_g, m_r, m_s, m_sw;
  int          m_lat;

  fp_mant_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
    .exp_diff(exp_diff), .a_ge_b(a_ge_b), .out_valid(out_valid),
    .out_ready(out_ready), .exp_out(exp_out), .big_mant(big_mant),
    .small_mant(small_mant), .guard(guard), .round_bit(round_bit),
    .sticky(sticky), .swapped(swapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: place the small mantissa at the top of a wide word and shift
  // by the exponent difference; the bits below become g, r and sticky.
  task automatic model(input logic [7:0] ea, input logic [7:0] eb,
                       input logic [23:0] ma, input logic [23:0] mb);
    int d;
    logic [23:0] sm;
    logic [63:0] v;
    m_sw  = (ea < eb);
    d     = m_sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
    m_big = m_sw ? mb : ma;
    sm    = m_sw ? ma : mb;
    m_exp = m_sw ? eb : ea;
    if (d > 26) begin
      m_small = '0; m_g = 1'b0; m_r = 1'b0; m_s = |sm;
      m_lat = 1;
    end else begin
      v = {sm, 40'd0} >> d;
      m_small = v[63:40]; m_g = v[39]; m_r = v[38]; m_s = |v[37:0];
      m_lat = (d == 0) ? 1 : 1 + (d + 3) / 4;
    end
`ifdef FP_ALIGN_ZERO_BYPASS_EN
    if (sm == '0) m_lat = 1;
`endif
  endtask

  task automatic drive(input logic [7:0] ea, input logic [7:0] eb,
                       input logic [23:0] ma, input logic [23:0] mb);
    exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
    a_ge_b   = (ea >= eb);
    exp_diff = (ea >= eb) ? ea - eb : eb - ea;
    in_valid = 1'b1;
  endtask

  task automatic scramble();
    exp_a = 8'($urandom); exp_b = 8'($urandom);
    mant_a = 24'($urandom); mant_b = 24'($urandom);
    exp_diff = 8'($urandom); a_ge_b = 1'($urandom);
  endtask

  // Called just after the accept edge; waits for the result and retires it.
  task automatic collect(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check({tag, "_latency"}, 64'(n), 64'(m_lat));
    check({tag, "_exp_big"}, {exp_out, big_mant}, {m_exp, m_big});
    check({tag, "_small"}, 64'(small_mant), 64'(m_small));
    check({tag, "_grs_sw"}, {guard, round_bit, sticky, swapped}, {m_g, m_r, m_s, m_sw});
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_retired"}, {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb);
    model(ea, eb, ma, mb);
    @(negedge clk);
    drive(ea, eb, ma, mb);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    collect(tag);
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(8'h00, 8'h00, 24'h0, 24'h0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hs", {in_ready, out_valid}, 2'b00);
    check("reset_data", {exp_out, big_mant, small_mant, guard, round_bit, sticky, swapped}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {in_ready, out_valid}, 2'b10);

    run_op("d2",     8'h85, 8'h83, 24'hC00000, 24'h800000);
    run_op("d5_swap",8'h83, 8'h88, 24'hC00000, 24'h800000);
    run_op("d3_stk", 8'h90, 8'h8D, 24'h800000, 24'h800001);
    run_op("d30",    8'hA0, 8'h82, 24'h800000, 24'h000001);
    run_op("d0",     8'h40, 8'h40, 24'hABCDEF, 24'h9FFFFF);
    run_op("d4",     8'h44, 8'h40, 24'h800000, 24'hFFFFFF);
    run_op("d26",    8'h20, 8'h3A, 24'h812345, 24'hC00000);
    run_op("d27",    8'h5B, 8'h40, 24'hC00000, 24'hFFFFFF);
    run_op("d255",   8'hFF, 8'h00, 24'h800000, 24'h000001);
    run_op("zero_sm",8'h60, 8'h50, 24'h900000, 24'h000000);

    // Result held under backpressure while a second operand waits
    model(8'h85, 8'h83, 24'hC00000, 24'h800000);
    @(negedge clk);
    drive(8'h85, 8'h83, 24'hC00000, 24'h800000);
    @(posedge clk);
    #1;
    drive(8'h70, 8'h76, 24'hF00000, 24'h8000FF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("hold_latency", 64'(n), 64'(m_lat));
    for (int i = 0; i < 3; i++) begin
      check("hold_hs", {out_valid, in_ready}, 2'b10);
      check("hold_data", {exp_out, big_mant, small_mant, guard, round_bit, sticky, swapped},
            {m_exp, m_big, m_small, m_g, m_r, m_s, m_sw});
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_release", {out_valid, in_ready}, 2'b01);
    model(8'h70, 8'h76, 24'hF00000, 24'h8000FF);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    collect("hold_second");

    // Reset in the middle of a long shift
    model(8'h90, 8'h7C, 24'h800000, 24'hFFFFFF);
    @(negedge clk);
    drive(8'h90, 8'h7C, 24'h800000, 24'hFFFFFF);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_low_hs", {out_valid, in_ready}, 2'b00);
    @(negedge clk);
    check("rst_edge_hs", {out_valid, in_ready}, 2'b00);
    check("rst_edge_data", {exp_out, big_mant, small_mant, guard, round_bit, sticky, swapped}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", {out_valid, in_ready}, 2'b01);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("rst_no_stale", 64'(bad), 64'd0);
    run_op("after_rst", 8'h31, 8'h30, 24'hFFFFFF, 24'hFFFFFF);

    for (int i = 0; i < 40; i++) begin
      int delta, e;
      ea = 8'($urandom_range(1, 254));
      delta = (i % 8 == 7) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 32));
      e = ($urandom_range(0, 1) == 1) ? int'(ea) + delta : int'(ea) - delta;
      if (e < 0) e = 0;
      if (e > 255) e = 255;
      eb = 8'(e);
      ma = {1'b1, 23'($urandom)};
      mb = {1'b1, 23'($urandom)};
      if (i % 10 == 3) mb = '0;
      if (i % 10 == 6) ma = 24'($urandom_range(0, 15));
      run_op("rand", ea, eb, ma, mb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
